// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock supervisor: sequences pll_rst, qualifies lock over a stability window,
// releases the downstream reset, and retries on timeout or loss of lock.
module pll_lock_ctrl #(
   parameter int RST_HOLD      = 64,
   parameter int LOCK_TIMEOUT  = 500000,
   parameter int LOCK_STABLE   = 1024,
   parameter int UNLOCK_FILTER = 4,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 20
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       user_rst_n,
   output logic       pll_ready,
   output logic       pll_fail,
   output logic [2:0] retry_cnt,
   output logic [7:0] lol_cnt,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      RST       = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   localparam int FILT_W = (UNLOCK_FILTER < 1) ? 1 : $clog2(UNLOCK_FILTER + 1);
   localparam longint CNT_LIM = longint'(1) << CNT_W;
   localparam logic [CNT_W-1:0]  RST_TC     = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  STABLE_TC  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0]  TIMER_MAX  = '1;
   localparam logic [FILT_W-1:0] FILT_TC    = FILT_W'(UNLOCK_FILTER);
   localparam logic [2:0]        RETRY_MAX  = 3'(MAX_RETRY);

   // A timer too narrow for its terminal counts would wrap and never reach them.
   if (RST_HOLD < 2 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 || UNLOCK_FILTER < 1 ||
       MAX_RETRY < 0 || MAX_RETRY > 7 || longint'(RST_HOLD) > CNT_LIM ||
       longint'(LOCK_TIMEOUT) > CNT_LIM || longint'(LOCK_STABLE) > CNT_LIM) begin : g_cfg_err
      $error("pll_lock_ctrl: parameter set does not fit CNT_W or legal ranges");
   end

   state_t             state, state_n;
   logic [CNT_W-1:0]   timer, timer_n, timer_inc;
   logic [2:0]         retry_n;
   logic [7:0]         lol_n;
   logic [FILT_W-1:0]  filt, filt_n;
   logic               sync_meta, lock_s;
   logic               pll_rst_d, user_rst_n_d, pll_ready_d, pll_fail_d;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sync_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         sync_meta <= pll_lock;
         lock_s    <= sync_meta;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state      <= RST;
         timer      <= '0;
         retry_cnt  <= '0;
         lol_cnt    <= '0;
         filt       <= '0;
         pll_rst    <= 1'b1;
         user_rst_n <= 1'b0;
         pll_ready  <= 1'b0;
         pll_fail   <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         retry_cnt  <= retry_n;
         lol_cnt    <= lol_n;
         filt       <= filt_n;
         pll_rst    <= pll_rst_d;
         user_rst_n <= user_rst_n_d;
         pll_ready  <= pll_ready_d;
         pll_fail   <= pll_fail_d;
      end
   end

   assign timer_inc = (timer == TIMER_MAX) ? timer : timer + 1'b1;

   always_comb begin
      state_n = state;
      timer_n = '0;
      retry_n = retry_cnt;
      lol_n   = lol_cnt;
      filt_n  = '0;
      if (relock_req && state != RST) begin
         state_n = RST;
         retry_n = '0;
      end else begin
         case (state)
            RST: begin
               if (timer == RST_TC) state_n = WAIT_LOCK;
               else                 timer_n = timer_inc;
            end
            // Lock is checked before the timeout so a late lock still qualifies.
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_n = STABLE;
               end else if (timer == TIMEOUT_TC) begin
                  if (retry_cnt == RETRY_MAX) begin
                     state_n = FAIL;
                  end else begin
                     state_n = RST;
                     retry_n = retry_cnt + 3'd1;
                  end
               end else begin
                  timer_n = timer_inc;
               end
            end
            STABLE: begin
               if (!lock_s)                state_n = WAIT_LOCK;
               else if (timer == STABLE_TC) state_n = RUN;
               else                         timer_n = timer_inc;
            end
            RUN: begin
               if (!lock_s) begin
                  filt_n = filt + 1'b1;
                  if (filt_n == FILT_TC) begin
                     state_n = RST;
                     filt_n  = '0;
                     retry_n = '0;
                     lol_n   = (lol_cnt == 8'hFF) ? lol_cnt : lol_cnt + 8'd1;
                  end
               end
            end
            FAIL:    state_n = FAIL;
            default: state_n = RST;
         endcase
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_comb begin
      pll_rst_d    = 1'b0;
      user_rst_n_d = 1'b0;
      pll_ready_d  = 1'b0;
      pll_fail_d   = 1'b0;
      case (state_n)
         RST:  pll_rst_d = 1'b1;
         RUN: begin
            user_rst_n_d = 1'b1;
            pll_ready_d  = 1'b1;
         end
         FAIL: begin
            pll_rst_d  = 1'b1;
            pll_fail_d = 1'b1;
         end
         default: pll_rst_d = 1'b0;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: a phase/elapsed-time reference model predicts every
// cycle's outputs, a monitor compares them one edge later.
module tb_pll_lock_ctrl;

   localparam int RST_HOLD      = 8;
   localparam int LOCK_TIMEOUT  = 32;
   localparam int LOCK_STABLE   = 16;
   localparam int UNLOCK_FILTER = 4;
   localparam int MAX_RETRY     = 2;
   localparam int CNT_W         = 8;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       pll_lock = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, user_rst_n, pll_ready, pll_fail;
   logic [2:0] retry_cnt, state_o;
   logic [7:0] lol_cnt;

   pll_lock_ctrl #(
      .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
      .UNLOCK_FILTER(UNLOCK_FILTER), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .relock_req(relock_req),
      .pll_rst(pll_rst), .user_rst_n(user_rst_n), .pll_ready(pll_ready), .pll_fail(pll_fail),
      .retry_cnt(retry_cnt), .lol_cnt(lol_cnt), .state_o(state_o)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic       pll_rst;
      logic       user_rst_n;
      logic       pll_ready;
      logic       pll_fail;
      logic [2:0] retry_cnt;
      logic [7:0] lol_cnt;
      logic [2:0] state_o;
   } obs_t;

   typedef enum int {PH_RESET, PH_WAIT, PH_QUAL, PH_RUN, PH_FAIL} phase_t;

   obs_t   expq[$];
   int     vectors = 0;
   int     miscompares = 0;

   phase_t phase = PH_RESET;
   int     elapsed = 0;
   int     attempts = 0;
   int     losses = 0;
   int     low_run = 0;
   bit     lock_pipe[$] = '{1'b0, 1'b0};

   // Advances the model by one clock edge given the inputs present at that edge.
   task automatic modelStep(input bit rst_n, input bit lock, input bit relock);
      bit seen;
      if (!rst_n) begin
         phase = PH_RESET; elapsed = 0; attempts = 0; losses = 0; low_run = 0;
         lock_pipe = '{1'b0, 1'b0};
         return;
      end
      seen = lock_pipe.pop_front();
      lock_pipe.push_back(lock);
      if (relock && phase != PH_RESET) begin
         phase = PH_RESET; elapsed = 0; attempts = 0; low_run = 0;
         return;
      end
      case (phase)
         PH_RESET: begin
            elapsed++;
            if (elapsed == RST_HOLD) begin phase = PH_WAIT; elapsed = 0; end
         end
         PH_WAIT: begin
            if (seen) begin
               phase = PH_QUAL; elapsed = 0;
            end else begin
               elapsed++;
               if (elapsed == LOCK_TIMEOUT) begin
                  elapsed = 0;
                  if (attempts == MAX_RETRY) phase = PH_FAIL;
                  else begin attempts++; phase = PH_RESET; end
               end
            end
         end
         PH_QUAL: begin
            if (!seen) begin
               phase = PH_WAIT; elapsed = 0;
            end else begin
               elapsed++;
               if (elapsed == LOCK_STABLE) begin phase = PH_RUN; elapsed = 0; end
            end
         end
         PH_RUN: begin
            low_run = seen ? 0 : low_run + 1;
            if (low_run == UNLOCK_FILTER) begin
               phase = PH_RESET; elapsed = 0; attempts = 0; low_run = 0;
               if (losses < 255) losses++;
            end
         end
         default: ;
      endcase
   endtask

   function automatic obs_t expectObs();
      obs_t e;
      e = '0;
      e.retry_cnt = 3'(attempts);
      e.lol_cnt   = 8'(losses);
      case (phase)
         PH_RESET: begin e.pll_rst = 1'b1; e.state_o = 3'd0; end
         PH_WAIT:  e.state_o = 3'd1;
         PH_QUAL:  e.state_o = 3'd2;
         PH_RUN:   begin e.user_rst_n = 1'b1; e.pll_ready = 1'b1; e.state_o = 3'd3; end
         default:  begin e.pll_rst = 1'b1; e.pll_fail = 1'b1; e.state_o = 3'd4; end
      endcase
      return e;
   endfunction

   task automatic applyStimulus(input bit rst_n, input bit lock, input bit relock);
      @(negedge sys_clk);
      sys_rst_n  = rst_n;
      pll_lock   = lock;
      relock_req = relock;
      modelStep(rst_n, lock, relock);
      expq.push_back(expectObs());
   endtask

   task automatic checkOutput(input obs_t exp);
      obs_t act;
      act = '{pll_rst, user_rst_n, pll_ready, pll_fail, retry_cnt, lol_cnt, state_o};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL outputs t=%0t got rst=%b urst_n=%b rdy=%b fail=%b retry=%0d lol=%0d st=%0d expected rst=%b urst_n=%b rdy=%b fail=%b retry=%0d lol=%0d st=%0d",
                  $time, act.pll_rst, act.user_rst_n, act.pll_ready, act.pll_fail, act.retry_cnt,
                  act.lol_cnt, act.state_o, exp.pll_rst, exp.user_rst_n, exp.pll_ready, exp.pll_fail,
                  exp.retry_cnt, exp.lol_cnt, exp.state_o);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s got %0d expected %0d", name, actual, required);
      end
   endtask

   task automatic runUntil(input phase_t target, input bit lock, input int max_cycles, input string name);
      int n = 0;
      while (phase != target && n < max_cycles) begin
         applyStimulus(1'b1, lock, 1'b0);
         n++;
      end
      if (phase != target) begin
         miscompares++;
         $display("[TB] FAIL %s bound of %0d cycles expired", name, max_cycles);
      end
   endtask

   task automatic sampleAfterEdge();
      @(posedge sys_clk);
      #2;
   endtask

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (expq.size() > 0) checkOutput(expq.pop_front());
      end
   end

   initial begin
      #1_000_000;
      miscompares++;
      $display("[TB] FAIL watchdog time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      bit lockv;
      int n;
      $display("[TB] start");

      // Nominal bring-up
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      runUntil(PH_WAIT, 1'b0, 20, "rst_hold");
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      runUntil(PH_RUN, 1'b1, 40, "bringup");
      sampleAfterEdge();
      checkValue("bringup_state", state_o, 3);
      checkValue("bringup_retry", retry_cnt, 0);
      checkValue("bringup_user_rst_n", user_rst_n, 1);

      // Retry then fail, then relock out of FAIL
      applyStimulus(1'b0, 1'b0, 1'b0);
      runUntil(PH_FAIL, 1'b0, 400, "retry_fail");
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      sampleAfterEdge();
      checkValue("fail_flag", pll_fail, 1);
      checkValue("fail_pll_rst", pll_rst, 1);
      checkValue("fail_retry", retry_cnt, 2);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      sampleAfterEdge();
      checkValue("relock_from_fail_state", state_o, 0);
      checkValue("relock_from_fail_retry", retry_cnt, 0);

      // Stability glitch
      runUntil(PH_QUAL, 1'b1, 60, "qual_entry");
      repeat ($urandom_range(3, 12)) applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runUntil(PH_RUN, 1'b1, 80, "glitch_requal");

      // Unlock filter: short dip rides through, full filter length exits
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
      sampleAfterEdge();
      checkValue("filter3_ready", pll_ready, 1);
      runUntil(PH_RESET, 1'b0, 12, "lol_exit");
      sampleAfterEdge();
      checkValue("lol_exit_user_rst_n", user_rst_n, 0);
      checkValue("lol_exit_count", lol_cnt, 1);

      // lol_cnt saturation
      for (int i = 0; i < 256; i++) begin
         runUntil(PH_RUN, 1'b1, 60, "sat_run");
         runUntil(PH_RESET, 1'b0, 12, "sat_lol");
      end
      sampleAfterEdge();
      checkValue("lol_saturated", lol_cnt, 255);

      // Synchronous reset during qualification
      runUntil(PH_QUAL, 1'b1, 60, "qual_before_rst");
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      sampleAfterEdge();
      checkValue("midrst_state", state_o, 0);
      checkValue("midrst_lol", lol_cnt, 0);
      checkValue("midrst_pll_rst", pll_rst, 1);
      runUntil(PH_RUN, 1'b1, 60, "run_after_midrst");

      // relock_req on the same edge as a WAIT_LOCK timeout
      runUntil(PH_RESET, 1'b0, 12, "lol_before_timeout");
      runUntil(PH_WAIT, 1'b0, 20, "wait1");
      runUntil(PH_RESET, 1'b0, 40, "timeout1");
      runUntil(PH_WAIT, 1'b0, 20, "wait2");
      n = 0;
      while (!(phase == PH_WAIT && elapsed == LOCK_TIMEOUT - 1) && n < 40) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         n++;
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      sampleAfterEdge();
      checkValue("relock_vs_timeout_retry", retry_cnt, 0);
      checkValue("relock_vs_timeout_state", state_o, 0);

      // Randomized traffic
      lockv = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 29) == 0) lockv = ~lockv;
         applyStimulus(($urandom_range(0, 399) != 0), lockv, ($urandom_range(0, 199) == 0));
      end

      repeat (3) @(posedge sys_clk);
      #2;
      if (expq.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
